// File: rtl/if_id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// if_id_hazard_ctrl
//
// Front-end hazard and sequencing controller for the 32-bit PA-RISC pipeline.
// Produces the PC / IF/ID load enables, the IF/ID synchronous flush, the ID/EX
// bubble request and the whole-pipe freeze. It resolves three event kinds, in
// priority order:
//   1. mem_busy      - the whole pipe holds (MEM_WAIT), with a timeout flag
//   2. branch_taken  - IF/ID is flushed and ID/EX bubbled for FLUSH_CYCLES
//   3. load_use      - one-cycle PC/IF/ID stall with an ID/EX bubble
// A saturating counter records every cycle the front end is not advancing.
//
// Optional feature (compile-time macro DELAY_SLOT_EN):
//   defined   - the delay-slot instruction sitting in ID during the branch
//               cycle proceeds unless branch_nullify=1 (ID_EX_nop follows
//               branch_nullify in that cycle only).
//   undefined - branch_nullify is ignored; every flush cycle bubbles ID/EX.
//
// Parameters:
//   FLUSH_CYCLES  cycles the flush/bubble is held after a taken branch (1..7)
//   MEM_TIMEOUT   consecutive mem_busy cycles before mem_timeout (1..255)
//   STALL_CNT_W   width of stall_count
//
// Ports:
//   clk            in   clock, rising edge
//   Reset          in   synchronous active-high reset
//   ID_rs1/ID_rs2  in   source registers of the instruction in ID
//   ID_rs1_used    in   ID instruction reads ID_rs1
//   ID_rs2_used    in   ID instruction reads ID_rs2
//   EX_load        in   instruction in EX is a load
//   EX_rd          in   destination register of the instruction in EX
//   branch_taken   in   branch resolved taken in EX this cycle
//   branch_nullify in   branch nullifies its delay slot (DELAY_SLOT_EN only)
//   mem_busy       in   data memory not ready
//   PC_LE          out  PC load enable
//   IF_ID_LE       out  IF/ID load enable
//   IF_ID_flush    out  IF/ID synchronous clear
//   ID_EX_nop      out  force ID/EX control to NOP
//   pipe_freeze    out  hold ID/EX, EX/MEM and MEM/WB
//   state          out  RUN=0, FLUSH=1, MEM_WAIT=2
//   stall_count    out  saturating count of non-advancing cycles
//   mem_timeout    out  sticky memory-wait timeout flag
// ---------------------------------------------------------------------------
module if_id_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [4:0]             ID_rs1,
  input  logic [4:0]             ID_rs2,
  input  logic                   ID_rs1_used,
  input  logic                   ID_rs2_used,
  input  logic                   EX_load,
  input  logic [4:0]             EX_rd,
  input  logic                   branch_taken,
  input  logic                   branch_nullify,
  input  logic                   mem_busy,
  output logic                   PC_LE,
  output logic                   IF_ID_LE,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_nop,
  output logic                   pipe_freeze,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   mem_timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  // The flush counter holds the number of flush cycles still to come after
  // the current one, so a branch loads FLUSH_CYCLES-1.
  localparam logic [2:0]             FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit                     MULTI_FLUSH  = (FLUSH_CYCLES > 1);
  localparam logic [7:0]             TIMEOUT_VAL  = 8'(MEM_TIMEOUT);
  localparam logic [7:0]             WAIT_MAX     = 8'hFF;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX    = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] STALL_ONE    = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_e                   state_q,       state_d;
  state_e                   ret_state_q,   ret_state_d;
  logic [2:0]               flush_cnt_q,   flush_cnt_d;
  logic [7:0]               wait_cnt_q,    wait_cnt_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q,   stall_cnt_d;
  logic                     mem_timeout_q, mem_timeout_d;

  logic   load_use;
  state_e eff_state;

`ifndef DELAY_SLOT_EN
  // branch_nullify only matters when the delay slot is honoured.
  logic unused_branch_nullify;
  assign unused_branch_nullify = branch_nullify;
`endif

  // Load-use hazard detection; r0 is hard-wired to zero and never conflicts.
  always_comb begin
    load_use = 1'b0;
    if (EX_load && (EX_rd != 5'd0)) begin
      load_use = (ID_rs1_used && (ID_rs1 == EX_rd)) ||
                 (ID_rs2_used && (ID_rs2 == EX_rd));
    end else begin
      load_use = 1'b0;
    end
  end

  // State whose rules govern this cycle: after a memory wait the controller
  // behaves as the state it was interrupted in.
  always_comb begin
    eff_state = ST_RUN;
    case (state_q)
      ST_RUN:      eff_state = ST_RUN;
      ST_FLUSH:    eff_state = ST_FLUSH;
      ST_MEM_WAIT: begin
        if (ret_state_q == ST_FLUSH) begin
          eff_state = ST_FLUSH;
        end else begin
          eff_state = ST_RUN;
        end
      end
      default:     eff_state = ST_RUN;
    endcase
  end

  // Main sequencing: pipeline control outputs and next FSM state.
  always_comb begin
    PC_LE       = 1'b1;
    IF_ID_LE    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_nop   = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = state_q;
    ret_state_d = ret_state_q;
    flush_cnt_d = flush_cnt_q;

    if (Reset) begin
      PC_LE       = 1'b0;
      IF_ID_LE    = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_nop   = 1'b1;
      state_d     = ST_RUN;
      ret_state_d = ST_RUN;
      flush_cnt_d = 3'd0;
    end else if (mem_busy) begin
      // Full hold; the interrupted state and flush progress are kept.
      PC_LE       = 1'b0;
      IF_ID_LE    = 1'b0;
      pipe_freeze = 1'b1;
      state_d     = ST_MEM_WAIT;
      ret_state_d = eff_state;
    end else if (branch_taken) begin
      IF_ID_flush = 1'b1;
`ifdef DELAY_SLOT_EN
      ID_EX_nop   = branch_nullify;
`else
      ID_EX_nop   = 1'b1;
`endif
      flush_cnt_d = FLUSH_RELOAD;
      if (MULTI_FLUSH) begin
        state_d = ST_FLUSH;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (eff_state)
        ST_FLUSH: begin
          // load_use is irrelevant here: the ID instruction is being squashed.
          IF_ID_flush = 1'b1;
          ID_EX_nop   = 1'b1;
          if (flush_cnt_q != 3'd0) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end else begin
            flush_cnt_d = 3'd0;
          end
          if (flush_cnt_q <= 3'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        ST_RUN: begin
          if (load_use) begin
            PC_LE     = 1'b0;
            IF_ID_LE  = 1'b0;
            ID_EX_nop = 1'b1;
          end else begin
            PC_LE     = 1'b1;
            IF_ID_LE  = 1'b1;
          end
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Consecutive mem_busy counter (saturating) and sticky timeout flag.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (Reset) begin
      wait_cnt_d    = 8'd0;
      mem_timeout_d = 1'b0;
    end else if (mem_busy) begin
      if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end else begin
        wait_cnt_d = WAIT_MAX;
      end
      if (wait_cnt_q == TIMEOUT_VAL) begin
        mem_timeout_d = 1'b1;
      end else begin
        mem_timeout_d = mem_timeout_q;
      end
    end else begin
      wait_cnt_d    = 8'd0;
      mem_timeout_d = mem_timeout_q;
    end
  end

  // Saturating count of cycles in which the front end does not advance.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Reset) begin
      stall_cnt_d = {STALL_CNT_W{1'b0}};
    end else if ((!PC_LE || pipe_freeze) && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State register; all reset handling is folded into the _d logic.
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    ret_state_q   <= ret_state_d;
    flush_cnt_q   <= flush_cnt_d;
    wait_cnt_q    <= wait_cnt_d;
    stall_cnt_q   <= stall_cnt_d;
    mem_timeout_q <= mem_timeout_d;
  end

  assign state       = state_q;
  assign stall_count = stall_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule
